// File: rtl/ecc_scrub_controller_if.sv
// Host transaction bus and ECC datapath bus seen by the scrub controller.
// The controller takes the slave view; the host/memory environment takes the master view.
interface ecc_scrub_controller_if;
    logic       host_req;
    logic       host_we;
    logic [3:0] host_addr;
    logic [7:0] host_wdata;
    logic       host_ready;
    logic [7:0] host_rdata;
    logic       host_rvalid;
    logic       host_err;

    logic [3:0] mem_addr;
    logic       mem_wr_en;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_err_corrected;

    modport slave (
        input  host_req, host_we, host_addr, host_wdata,
        input  mem_rdata, mem_err_corrected,
        output host_ready, host_rdata, host_rvalid, host_err,
        output mem_addr, mem_wr_en, mem_wdata
    );

    modport master (
        output host_req, host_we, host_addr, host_wdata,
        output mem_rdata, mem_err_corrected,
        input  host_ready, host_rdata, host_rvalid, host_err,
        input  mem_addr, mem_wr_en, mem_wdata
    );
endinterface

// File: rtl/ecc_scrub_controller.sv
// ECC scrub controller: arbitrates host reads/writes against a periodic background
// scrub walk of a 16-word ECC memory, writing back any word the decoder had to correct.
module ecc_scrub_controller #(
    parameter int unsigned SCRUB_INTERVAL = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    ecc_scrub_controller_if.slave        bus,
    input  logic                         scrub_en,
    output logic [7:0]                   err_count,
    output logic                         scrub_busy,
    output logic                         scrub_pass_done
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] HOST_RD  = 3'd1;
    localparam logic [2:0] HOST_WR  = 3'd2;
    localparam logic [2:0] HOST_WB  = 3'd3;
    localparam logic [2:0] SCRUB_RD = 3'd4;
    localparam logic [2:0] SCRUB_WB = 3'd5;

    localparam logic [15:0] CNT_LAST = 16'(SCRUB_INTERVAL - 1);

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic        start_scrub;
    logic        count_err;

    logic [3:0]  addr_lat;
    logic [7:0]  wdata_lat;
    logic [7:0]  rdata_q;
    logic        rvalid_q;
    logic        err_q;

    logic [3:0]  scrub_ptr;
    logic [3:0]  scrub_addr;
    logic [7:0]  scrub_data;
    logic [15:0] interval_cnt;
    logic        scrub_pending;
    logic        pass_done_q;
    logic [7:0]  err_cnt_q;

    logic [3:0]  mem_addr_c;
    logic [7:0]  mem_wdata_c;
    logic        mem_wr_en_c;
    logic        host_ready_c;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Next-state decode: host always wins over a pending scrub step
    always_comb begin
        state_nxt   = IDLE;
        start_scrub = 1'b0;
        case (state)
            IDLE: begin
                if (bus.host_req) begin
                    state_nxt = bus.host_we ? HOST_WR : HOST_RD;
                end else if (scrub_pending) begin
                    state_nxt   = SCRUB_RD;
                    start_scrub = 1'b1;
                end
            end
            HOST_RD:  state_nxt = bus.mem_err_corrected ? HOST_WB : IDLE;
            SCRUB_RD: state_nxt = bus.mem_err_corrected ? SCRUB_WB : IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Datapath drive is a pure decode of the current state, so reset silences it at once
    always_comb begin
        mem_addr_c   = 4'h0;
        mem_wdata_c  = 8'h00;
        mem_wr_en_c  = 1'b0;
        host_ready_c = 1'b0;
        case (state)
            HOST_WR: begin
                mem_addr_c   = addr_lat;
                mem_wdata_c  = wdata_lat;
                mem_wr_en_c  = 1'b1;
                host_ready_c = 1'b1;
            end
            HOST_RD: begin
                mem_addr_c   = addr_lat;
                host_ready_c = 1'b1;
            end
            HOST_WB: begin
                mem_addr_c  = addr_lat;
                mem_wdata_c = rdata_q;
                mem_wr_en_c = 1'b1;
            end
            SCRUB_RD: begin
                mem_addr_c = scrub_ptr;
            end
            SCRUB_WB: begin
                mem_addr_c  = scrub_addr;
                mem_wdata_c = scrub_data;
                mem_wr_en_c = 1'b1;
            end
            default: ;
        endcase
    end

    assign count_err = ((state == HOST_RD) || (state == SCRUB_RD)) && bus.mem_err_corrected;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            addr_lat  <= 4'h0;
            wdata_lat <= 8'h00;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && bus.host_req) begin
                addr_lat  <= bus.host_addr;
                wdata_lat <= bus.host_wdata;
            end
        end
    end

    // Host read return stage: data/flag registered at the end of HOST_RD
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q  <= 8'h00;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= (state == HOST_RD);
            err_q    <= (state == HOST_RD) && bus.mem_err_corrected;
            if (state == HOST_RD) begin
                rdata_q <= bus.mem_rdata;
            end
        end
    end

    // Scrub read stage: capture corrected word and its address for a possible writeback
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scrub_ptr   <= 4'h0;
            scrub_addr  <= 4'h0;
            scrub_data  <= 8'h00;
            pass_done_q <= 1'b0;
        end else begin
            pass_done_q <= (state == SCRUB_RD) && (scrub_ptr == 4'hF);
            if (state == SCRUB_RD) begin
                scrub_data <= bus.mem_rdata;
                scrub_addr <= scrub_ptr;
                scrub_ptr  <= scrub_ptr + 4'd1;
            end
        end
    end

    // Interval timer freezes while a step is pending so a starved step is delayed, never lost
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            interval_cnt  <= 16'h0000;
            scrub_pending <= 1'b0;
        end else if (!scrub_en) begin
            interval_cnt  <= 16'h0000;
            scrub_pending <= 1'b0;
        end else if (scrub_pending) begin
            if (start_scrub) begin
                scrub_pending <= 1'b0;
            end
        end else if (interval_cnt == CNT_LAST) begin
            interval_cnt  <= 16'h0000;
            scrub_pending <= 1'b1;
        end else begin
            interval_cnt <= interval_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_q <= 8'h00;
        end else if (count_err) begin
            err_cnt_q <= sat_inc8(err_cnt_q);
        end
    end

    assign bus.mem_addr    = mem_addr_c;
    assign bus.mem_wdata   = mem_wdata_c;
    assign bus.mem_wr_en   = mem_wr_en_c;
    assign bus.host_ready  = host_ready_c;
    assign bus.host_rdata  = rdata_q;
    assign bus.host_rvalid = rvalid_q;
    assign bus.host_err    = err_q;

    assign err_count       = err_cnt_q;
    assign scrub_busy      = (state == SCRUB_RD) || (state == SCRUB_WB);
    assign scrub_pass_done = pass_done_q;

endmodule
